// File: rtl/d_input_debouncer_if.sv
// Debouncer signal bundle: raw input towards the debouncer, clean level and
// edge pulses back. master = producer of din / consumer of results, slave = debouncer.
interface d_input_debouncer_if;
    logic       din;
    logic       dout;
    logic       rise;
    logic       fall;
`ifdef DEBOUNCE_EDGE_COUNT_EN
    logic [7:0] edge_cnt;

    modport master (
        output din,
        input  dout,
        input  rise,
        input  fall,
        input  edge_cnt
    );

    modport slave (
        input  din,
        output dout,
        output rise,
        output fall,
        output edge_cnt
    );
`else
    modport master (
        output din,
        input  dout,
        input  rise,
        input  fall
    );

    modport slave (
        input  din,
        output dout,
        output rise,
        output fall
    );
`endif
endinterface

// File: rtl/d_input_debouncer.sv
// Input debouncer: 2-flop synchroniser + stability-counter FSM giving a clean
// level (dout) and 1-cycle rise/fall pulses. Ports: clk, rst (sync, active-low),
// bus.slave {din, dout, rise, fall[, edge_cnt with DEBOUNCE_EDGE_COUNT_EN]}.
module d_input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    d_input_debouncer_if.slave bus
);

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE_CHK,
        S_HIGH,
        S_FALL_CHK
    } state_t;

    // Last count value before a new level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             din_s;

    assign din_s = sync2_q;

    always_comb begin
        sync1_d = bus.din;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            S_LOW: begin
                if (din_s) begin
                    state_d = S_RISE_CHK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            S_RISE_CHK: begin
                if (!din_s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!din_s) begin
                    state_d = S_FALL_CHK;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_FALL_CHK: begin
                if (din_s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                dout_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;

`ifdef DEBOUNCE_EDGE_COUNT_EN
    logic [7:0] edge_cnt_q, edge_cnt_d;

    // Counts the registered rise pulse; wraps silently at 255.
    always_comb begin
        edge_cnt_d = edge_cnt_q + {7'd0, rise_q};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            edge_cnt_q <= 8'd0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign bus.edge_cnt = edge_cnt_q;
`endif

endmodule

// File: tb/tb_d_input_debouncer.sv
// Testbench for d_input_debouncer (STABLE_CYCLES=4): vector table plus
// hand-written sequences for fall qualification, mid-count reset and edge count.
module tb_d_input_debouncer;

    typedef struct {
        logic rst;
        logic din;
        logic dout;
        logic rise;
        logic fall;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];

    d_input_debouncer_if bus ();

    d_input_debouncer #(
        .STABLE_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic d, input logic o,
                       input logic ri, input logic f, input int n);
        vec_t v;
        v.rst  = r;
        v.din  = d;
        v.dout = o;
        v.rise = ri;
        v.fall = f;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic d);
        rst     = r;
        bus.din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic o,
                         input logic ri, input logic f);
        n_cmp++;
        if (bus.dout !== o || bus.rise !== ri || bus.fall !== f) begin
            n_bad++;
            $display("FAIL %s: got dout/rise/fall=%b%b%b exp %b%b%b",
                     name, bus.dout, bus.rise, bus.fall, o, ri, f);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b0;
        bus.din = 1'b0;

        // reset with din high, then release: rise on 6th posedge after release
        add(0, 1, 0, 0, 0, 3);
        add(1, 1, 0, 0, 0, 5);
        add(1, 1, 1, 1, 0, 1);
        add(1, 1, 1, 0, 0, 1);
        // low 2, high 1, low held: single fall after 4 clean low samples
        add(1, 0, 1, 0, 0, 2);
        add(1, 1, 1, 0, 0, 1);
        add(1, 0, 1, 0, 0, 5);
        add(1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 1);
        // 3-cycle high glitch is rejected
        add(1, 1, 0, 0, 0, 3);
        add(1, 0, 0, 0, 0, 8);
        // clean 0->1: rise at N+5, gone at N+6
        add(1, 1, 0, 0, 0, 5);
        add(1, 1, 1, 1, 0, 1);
        add(1, 1, 1, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].din);
            check($sformatf("vec%0d", i), vecs[i].dout,
                  vecs[i].rise, vecs[i].fall);
        end

        // clean fall from high: fall 5 posedges after din drops
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            check($sformatf("fall%0d", i), i < 5, 1'b0, i == 5);
        end

        // reset while in S_RISE_CHK with cnt=2, then full requalification
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1);
            check($sformatf("pre_rst%0d", i), 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1);
        check("mid_rst", 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 7; j++) begin
            step(1'b1, 1'b1);
            check($sformatf("requal%0d", j), j >= 5, j == 5, 1'b0);
        end

`ifdef DEBOUNCE_EDGE_COUNT_EN
        step(1'b0, 1'b0);
        n_cmp++;
        if (bus.edge_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL edge_rst: got %0d exp 0", bus.edge_cnt);
        end
        for (int p = 1; p <= 257; p++) begin
            for (int k = 0; k < 7; k++) step(1'b1, 1'b1);
            for (int k = 0; k < 7; k++) step(1'b1, 1'b0);
            if (p == 1 || p == 255 || p == 256 || p == 257) begin
                n_cmp++;
                if (bus.edge_cnt !== 8'(p)) begin
                    n_bad++;
                    $display("FAIL edge_cnt%0d: got %0d exp %0d",
                             p, bus.edge_cnt, 8'(p));
                end
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
